// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one byte
// out on device-generated clock edges and reports the device ACK or an error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       key_clk_oe,
  output logic       key_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_clk_r0, r_clk_r1;
  logic             r_data_r0, r_data_r1;
  logic [7:0]       r_byte, w_byte_next;
  logic             r_parity, w_parity_next;
  logic [3:0]       r_idx, w_idx_next;
  logic             r_data_oe, w_data_oe_next;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_next;
  logic             w_neg;
  logic             w_timed;
  logic             w_timeout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_clk_r0  <= 1'b1;
      r_clk_r1  <= 1'b1;
      r_data_r0 <= 1'b1;
      r_data_r1 <= 1'b1;
      r_byte    <= '0;
      r_parity  <= 1'b0;
      r_idx     <= '0;
      r_data_oe <= 1'b0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clk_r0  <= key_clk;
      r_clk_r1  <= r_clk_r0;
      r_data_r0 <= key_data;
      r_data_r1 <= r_data_r0;
      r_byte    <= w_byte_next;
      r_parity  <= w_parity_next;
      r_idx     <= w_idx_next;
      r_data_oe <= w_data_oe_next;
      r_inh_cnt <= w_inh_cnt_next;
      r_to_cnt  <= w_to_cnt_next;
    end
  end

  assign w_neg     = r_clk_r1 & ~r_clk_r0;
  assign w_timed   = (r_state == S_BITS) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout = w_timed && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next   = r_state;
    w_byte_next    = r_byte;
    w_parity_next  = r_parity;
    w_idx_next     = r_idx;
    w_data_oe_next = r_data_oe;
    w_inh_cnt_next = r_inh_cnt;
    w_to_cnt_next  = r_to_cnt;

    // Counter stops at the terminal count; reaching it always leaves the timed states.
    if (w_timed && !w_timeout) begin
      w_to_cnt_next = r_to_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_inh_cnt_next = '0;
        w_data_oe_next = 1'b0;
        if (tx_valid) begin
          w_byte_next   = tx_data;
          w_parity_next = ~^tx_data;
          w_state_next  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_state_next = S_START;
        end else begin
          w_inh_cnt_next = r_inh_cnt + 1'b1;
        end
      end
      S_START: begin
        w_data_oe_next = 1'b1;
        w_idx_next     = '0;
        w_to_cnt_next  = '0;
        w_state_next   = S_BITS;
      end
      S_BITS: begin
        if (w_timeout) begin
          w_data_oe_next = 1'b0;
          w_state_next   = S_ERR;
        end else if (w_neg) begin
          w_idx_next = r_idx + 4'd1;
          if (r_idx < 4'd8) begin
            w_data_oe_next = ~r_byte[r_idx[2:0]];
          end else if (r_idx == 4'd8) begin
            w_data_oe_next = ~r_parity;
          end else begin
            w_data_oe_next = 1'b0;
            w_state_next   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (w_timeout) begin
          w_state_next = S_ERR;
        end else if (w_neg) begin
          w_state_next = r_data_r1 ? S_ERR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_state_next = S_ERR;
        end else if (r_clk_r1 && r_data_r1) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign key_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_START);
  assign key_data_oe = (r_state == S_START) || ((r_state == S_BITS) && r_data_oe);
  assign tx_done     = (r_state == S_DONE);
  assign tx_err      = (r_state == S_ERR);

endmodule
